// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 host transmitter
//
// Holds the transmit FSM state enum and the bit positions of the status word
// returned on DAT_O.

package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACKW,
        IDLEWAIT
    } state_t;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_ACK     = 2;
    localparam int ST_ERR     = 3;
    localparam int ST_OVR     = 4;
    localparam int ST_CMD_LSB = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - synchroniser, glitch filter and fall-edge detector for one PS/2 line
//
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   raw   asynchronous pin level
//   filt  filtered level; follows the line only after FILTER_LEN equal samples
//   fall  one-cycle pulse when filt goes 1 -> 0

module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync_0;
    logic          sync_1;
    logic [CW-1:0] cnt;

    // Lines idle high, so the synchroniser and filter come out of reset high
    // to avoid a spurious falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0 <= 1'b1;
            sync_1 <= 1'b1;
            filt   <= 1'b1;
            cnt    <= '0;
            fall   <= 1'b0;
        end else begin
            sync_0 <= raw;
            sync_1 <= sync_0;
            fall   <= 1'b0;
            if (sync_1 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // FILTER_LEN consecutive differing samples: accept the new level.
                filt <= sync_1;
                fall <= filt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - bus slave that sends one command byte host-to-device over PS/2
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   STB, WE, DAT_I     bus strobe, write enable, write data ([7:0] = command)
//   ACK, DAT_O         bus acknowledge, registered status word
//   ps2c_in, ps2d_in   raw PS/2 clock / data pin levels
//   ps2c_oe, ps2d_oe   1 = pull the corresponding line low
//   busy               transfer in progress

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        STB,
    input  logic        WE,
    input  logic [31:0] DAT_I,
    output logic        ACK,
    output logic [31:0] DAT_O,
    input  logic        ps2c_in,
    input  logic        ps2d_in,
    output logic        ps2c_oe,
    output logic        ps2d_oe,
    output logic        busy
);

    import ps2_pkg::*;

    localparam logic [31:0] INH_LAST = 32'(INHIBIT_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        stb_d;
    logic        wr_edge;
    logic [7:0]  cmd;
    logic        parity;
    logic        done;
    logic        ack_ok;
    logic        err;
    logic        overrun;
    logic [31:0] inh_cnt;
    logic [31:0] to_cnt;
    logic [3:0]  bit_n;
    logic        c_filt;
    logic        c_fall;
    logic        d_filt;
    logic        d_fall_unused;
    logic        active;
    logic        to_hit;
    logic [31:0] status;
    logic        dat_unused;

    assign dat_unused = &{1'b0, DAT_I[31:8]};

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2c_in),
        .filt (c_filt),
        .fall (c_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2d_in),
        .filt (d_filt),
        .fall (d_fall_unused)
    );

    // Only the rising edge of STB starts a transaction, so a held strobe
    // cannot launch a second transfer.
    assign wr_edge = STB & ~stb_d & WE;

    // States in which the device owns the clock and may stall forever.
    assign active = (state == RTS) || (state == SHIFT) ||
                    (state == ACKW) || (state == IDLEWAIT);
    assign to_hit = active && !c_fall && (to_cnt == TO_LAST);

    always_comb begin
        status                       = '0;
        status[ST_BUSY]              = busy;
        status[ST_DONE]              = done;
        status[ST_ACK]               = ack_ok;
        status[ST_ERR]               = err;
        status[ST_OVR]               = overrun;
        status[ST_CMD_LSB +: 8]      = cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            stb_d   <= 1'b0;
            ACK     <= 1'b0;
            DAT_O   <= '0;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            busy    <= 1'b0;
            cmd     <= '0;
            parity  <= 1'b0;
            done    <= 1'b0;
            ack_ok  <= 1'b0;
            err     <= 1'b0;
            overrun <= 1'b0;
            inh_cnt <= '0;
            to_cnt  <= '0;
            bit_n   <= '0;
        end else begin
            stb_d <= STB;
            ACK   <= STB;
            DAT_O <= status;

            if (active) begin
                to_cnt <= c_fall ? '0 : to_cnt + 32'd1;
            end

            // A write while a transfer is in flight (including the cycle that
            // completes it) is dropped and only flagged.
            if (wr_edge && state != IDLE) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (wr_edge) begin
                        cmd     <= DAT_I[7:0];
                        parity  <= ~^DAT_I[7:0];
                        done    <= 1'b0;
                        ack_ok  <= 1'b0;
                        err     <= 1'b0;
                        overrun <= 1'b0;
                        inh_cnt <= '0;
                        ps2c_oe <= 1'b1;
                        busy    <= 1'b1;
                        state   <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        // Release clock and assert the start bit together.
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b1;
                        to_cnt  <= '0;
                        bit_n   <= '0;
                        state   <= RTS;
                    end else begin
                        inh_cnt <= inh_cnt + 32'd1;
                    end
                end
                RTS: begin
                    if (c_fall) begin
                        ps2d_oe <= ~cmd[0];
                        bit_n   <= 4'd1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // bit_n counts device clock falls seen so far; this fall is bit_n+1.
                    if (c_fall) begin
                        bit_n <= bit_n + 4'd1;
                        if (bit_n < 4'd8) begin
                            ps2d_oe <= ~cmd[bit_n[2:0]];
                        end else if (bit_n == 4'd8) begin
                            ps2d_oe <= ~parity;
                        end else begin
                            ps2d_oe <= 1'b0;
                            state   <= ACKW;
                        end
                    end
                end
                ACKW: begin
                    if (c_fall) begin
                        ack_ok <= ~d_filt;
                        state  <= IDLEWAIT;
                    end
                end
                IDLEWAIT: begin
                    if (c_filt && d_filt) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (to_hit) begin
                err     <= 1'b1;
                done    <= 1'b1;
                ps2c_oe <= 1'b0;
                ps2d_oe <= 1'b0;
                busy    <= 1'b0;
                state   <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model

module tb_ps2_host_tx;

    localparam int INH = 200;
    localparam int TO  = 2000;
    localparam int FL  = 4;
    localparam int H   = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        STB = 1'b0;
    logic        WE = 1'b0;
    logic [31:0] DAT_I = '0;
    logic        ACK;
    logic [31:0] DAT_O;
    logic        ps2c_in;
    logic        ps2d_in;
    logic        ps2c_oe;
    logic        ps2d_oe;
    logic        busy;
    logic        dev_clk = 1'b1;
    logic        dev_data = 1'b1;

    int checks = 0;
    int errors = 0;

    assign ps2c_in = dev_clk & ~ps2c_oe;
    assign ps2d_in = dev_data & ~ps2d_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN(FL)
    ) dut (
        .clk(clk), .rst(rst), .STB(STB), .WE(WE), .DAT_I(DAT_I),
        .ACK(ACK), .DAT_O(DAT_O), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .busy(busy)
    );

    function automatic logic exp_parity(input logic [7:0] b);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(b[i]);
        return (n % 2) == 0;
    endfunction

    function automatic logic [31:0] exp_status(input logic [7:0] c, input int ack, input int er, input int ovr);
        return 32'(int'(c) * 256 + ovr * 16 + er * 8 + ack * 4 + 2);
    endfunction

    task automatic bus_write(input logic [31:0] d, output logic a1, output logic a2);
        @(negedge clk);
        STB = 1'b1; WE = 1'b1; DAT_I = d;
        @(negedge clk);
        a1 = ACK;
        STB = 1'b0; WE = 1'b0;
        @(negedge clk);
        a2 = ACK;
    endtask

    // Device side: measures the inhibit, then either clocks 11 bits
    // (mode 0 = ack, 1 = nack) or never clocks (mode 2).
    task automatic dev_run(input int mode, output int inh_len, output int dhold,
                           output logic [7:0] rx, output logic rx_par,
                           output logic rx_stop, output logic tmo);
        int n;
        inh_len = 0; dhold = 0; rx = '0; rx_par = 1'b0; rx_stop = 1'b0; tmo = 1'b0; n = 0;
        while (!ps2c_oe && n < 50) begin @(negedge clk); n++; end
        if (!ps2c_oe) begin
            tmo = 1'b1;
        end else begin
            while (ps2c_oe && inh_len < 4 * INH) begin inh_len++; @(negedge clk); end
            if (mode == 2) begin
                while (ps2d_oe && dhold < 4 * TO) begin dhold++; @(negedge clk); end
            end else begin
                repeat (10) @(negedge clk);
                for (int k = 1; k <= 11; k++) begin
                    dev_clk = 1'b0;
                    repeat (H) @(negedge clk);
                    dev_clk = 1'b1;
                    if (k <= 8) rx[k-1] = ps2d_in;
                    else if (k == 9) rx_par = ps2d_in;
                    else if (k == 10) begin
                        rx_stop = ps2d_in;
                        if (mode == 0) dev_data = 1'b0;
                    end
                    repeat (H) @(negedge clk);
                end
                dev_data = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(output logic tmo);
        int n = 0;
        while (busy && n < 3 * TO) begin @(negedge clk); n++; end
        tmo = busy;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ACK, ps2c_oe, ps2d_oe, busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs: got %b required 0000", {ACK, ps2c_oe, ps2d_oe, busy});
        end
        checks++;
        if (DAT_O !== 32'h0) begin
            errors++; $display("FAIL reset_dat_o: got %h required 00000000", DAT_O);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_transfer(input logic [7:0] c, input int mode);
        int inh, dh;
        logic [7:0] rx;
        logic p, s, t, a1, a2, w;
        logic [31:0] exp;
        fork
            bus_write({24'($urandom), c}, a1, a2);
            dev_run(mode, inh, dh, rx, p, s, t);
        join
        checks++;
        if (a1 !== 1'b1 || a2 !== 1'b0) begin
            errors++; $display("FAIL xfer_ack cmd=%h: got %b%b required 10", c, a1, a2);
        end
        checks++;
        if (t !== 1'b0 || inh != INH) begin
            errors++; $display("FAIL xfer_inhibit cmd=%h: got %0d cycles (tmo %b) required %0d", c, inh, t, INH);
        end
        if (mode == 2) begin
            checks++;
            if (dh != TO) begin
                errors++; $display("FAIL timeout_len cmd=%h: got %0d required %0d", c, dh, TO);
            end
            checks++;
            if (ps2c_oe !== 1'b0 || ps2d_oe !== 1'b0) begin
                errors++; $display("FAIL timeout_release: got %b%b required 00", ps2c_oe, ps2d_oe);
            end
        end else begin
            checks++;
            if (rx !== c) begin
                errors++; $display("FAIL xfer_data: got %h required %h", rx, c);
            end
            checks++;
            if (p !== exp_parity(c) || s !== 1'b1) begin
                errors++; $display("FAIL xfer_parity_stop cmd=%h: got %b%b required %b1", c, p, s, exp_parity(c));
            end
        end
        wait_idle(w);
        exp = exp_status(c, (mode == 0) ? 1 : 0, (mode == 2) ? 1 : 0, 0);
        checks++;
        if (w !== 1'b0 || DAT_O !== exp) begin
            errors++; $display("FAIL xfer_status mode=%0d: got %h (stuck %b) required %h", mode, DAT_O, w, exp);
        end
    endtask

    task automatic test_overrun();
        int inh, dh;
        logic [7:0] rx;
        logic p, s, t, a1, a2, b1, b2, bsy, w;
        fork
            dev_run(0, inh, dh, rx, p, s, t);
            begin
                bus_write(32'h0000_00ED, a1, a2);
                repeat (INH + 400) @(negedge clk);
                bsy = busy & ~ps2c_oe;
                bus_write(32'h0000_0000, b1, b2);
            end
        join
        checks++;
        if (bsy !== 1'b1 || b1 !== 1'b1 || b2 !== 1'b0) begin
            errors++; $display("FAIL overrun_ack: got busy %b ack %b%b required 1 10", bsy, b1, b2);
        end
        checks++;
        if (rx !== 8'hED) begin
            errors++; $display("FAIL overrun_wire: got %h required ed", rx);
        end
        wait_idle(w);
        checks++;
        if (DAT_O !== exp_status(8'hED, 1, 0, 1)) begin
            errors++; $display("FAIL overrun_status: got %h required %h", DAT_O, exp_status(8'hED, 1, 0, 1));
        end
    endtask

    task automatic test_reset_mid();
        logic a1, a2;
        int n = 0;
        bus_write(32'h0000_0012, a1, a2);
        while (!(busy && !ps2c_oe) && n < 4 * INH) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        checks++;
        if (busy !== 1'b1 || ps2d_oe !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got busy %b d_oe %b required 1 1", busy, ps2d_oe);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ps2c_oe, ps2d_oe, busy} !== 3'b000 || DAT_O !== 32'h0) begin
            errors++; $display("FAIL rstmid_post: got oe %b%b busy %b dat %h required 00 0 00000000", ps2c_oe, ps2d_oe, busy, DAT_O);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_long_stb();
        int inh, dh, acks;
        logic [7:0] c, rx;
        logic p, s, t, first_ack, late_ack, w;
        c = 8'($urandom);
        acks = 0; first_ack = 1'b0; late_ack = 1'b1;
        fork
            dev_run(0, inh, dh, rx, p, s, t);
            begin
                @(negedge clk);
                STB = 1'b1; WE = 1'b1; DAT_I = {24'($urandom), c};
                for (int i = 1; i <= 8; i++) begin
                    @(negedge clk);
                    if (ACK) acks++;
                    if (i == 1) first_ack = ACK;
                    if (i == 6) late_ack = ACK;
                    if (i == 5) begin STB = 1'b0; WE = 1'b0; end
                end
            end
        join
        checks++;
        if (acks != 5 || first_ack !== 1'b1 || late_ack !== 1'b0) begin
            errors++; $display("FAIL long_stb_ack: got %0d cycles first %b after %b required 5 1 0", acks, first_ack, late_ack);
        end
        checks++;
        if (rx !== c) begin
            errors++; $display("FAIL long_stb_data: got %h required %h", rx, c);
        end
        wait_idle(w);
        repeat (50) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || DAT_O !== exp_status(c, 1, 0, 0)) begin
            errors++; $display("FAIL long_stb_single: got busy %b dat %h required 0 %h", busy, DAT_O, exp_status(c, 1, 0, 0));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            test_transfer(8'($urandom), int'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_transfer(8'hED, 0);
        test_transfer(8'hF4, 0);
        test_transfer(8'h55, 2);
        test_transfer(8'h3C, 1);
        test_overrun();
        test_reset_mid();
        test_long_stb();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
